ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/ex_mem_entry.sv | 33 +++
 rtl/ex_mem_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: occupancy states,
// default widths and the control bundle that travels with each entry.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_mem_entry.sv
// One load-enabled EX/MEM entry register, cleared to zero by the
// asynchronous active-low reset.
module ex_mem_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage built as a 2-entry skid buffer: the head entry drives
// the outputs and the skid entry absorbs one extra entry when MEM stalls.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              Branch,
    input  logic [DATA_W-1:0] BranchTarget,
    input  logic              Flush,
    input  logic              Out_Ready,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_ALUResult,
    output logic [DATA_W-1:0] Out_WriteData,
    output logic [DATA_W-1:0] Out_BranchTarget,
    output logic [REG_W-1:0]  Out_WriteReg,
    output logic              Out_RegWrite,
    output logic              Out_MemRead,
    output logic              Out_MemWrite,
    output logic              Out_MemToReg,
    output logic              Out_PCSrc,
    output logic [1:0]        Count
);

    localparam int ENTRY_W = 3 * DATA_W + REG_W + CTRL_W;

    state_e state_d;
    state_e state_q;

    logic               accept;
    logic               pop;
    logic               head_load;
    logic               skid_load;
    logic               head_from_skid;
    ctrl_t              in_ctrl;
    ctrl_t              head_ctrl;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_d;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] skid_q;

    assign In_Ready  = (state_q != TWO);
    assign Out_Valid = (state_q != EMPTY);
    assign Count     = state_q;
    assign accept    = In_Valid & In_Ready;
    assign pop       = Out_Valid & Out_Ready;

    // The branch decision is resolved here so MEM only sees the final PCSrc.
    assign in_ctrl.reg_write  = RegWrite;
    assign in_ctrl.mem_read   = MemRead;
    assign in_ctrl.mem_write  = MemWrite;
    assign in_ctrl.mem_to_reg = MemToReg;
    assign in_ctrl.pc_src     = Branch & Zero;

    assign in_entry = {ALUResult, WriteData, BranchTarget, WriteReg, in_ctrl};
    assign head_d   = head_from_skid ? skid_q : in_entry;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (pop) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush suppresses loads too, so data outputs keep their last value.
        if (Flush) begin
            state_d   = EMPTY;
            head_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    ex_mem_entry #(.W(ENTRY_W)) u_head (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    ex_mem_entry #(.W(ENTRY_W)) u_skid (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign {Out_ALUResult, Out_WriteData, Out_BranchTarget, Out_WriteReg, head_ctrl} = head_q;

    assign Out_RegWrite = Out_Valid & head_ctrl.reg_write;
    assign Out_MemRead  = Out_Valid & head_ctrl.mem_read;
    assign Out_MemWrite = Out_Valid & head_ctrl.mem_write;
    assign Out_MemToReg = Out_Valid & head_ctrl.mem_to_reg;
    assign Out_PCSrc    = Out_Valid & head_ctrl.pc_src;

endmodule
